// File: rtl/count_sequencer_pkg.sv
// Shared constants and state encoding for the count sequencer.
package count_sequencer_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/count_sequencer_load_counter4.sv
// 4-bit loadable up-counter; a load takes priority over a count.
module load_counter4
    import count_sequencer_pkg::*;
(
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             Load,
    input  logic             Count,
    input  logic [CNT_W-1:0] I,
    output logic [CNT_W-1:0] A,
    output logic             C_out
);

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b)   A <= '0;
        else if (Load)  A <= I;
        else if (Count) A <= A + 1'b1;
    end

    // Carry out flags that the next count wraps 15 -> 0.
    assign C_out = Count & (&A);

endmodule

// File: rtl/count_sequencer.sv
// Start/pause/abort sequencer driving a loadable counter through
// repeated or single Load_val..Terminal periods.
module count_sequencer
    import count_sequencer_pkg::*;
(
    input  logic             CLK,
    input  logic             Clear_b,
    input  logic             Start,
    input  logic             Pause,
    input  logic             Abort,
    input  logic             Auto_reload,
    input  logic [CNT_W-1:0] Load_val,
    input  logic [CNT_W-1:0] Terminal,
    output logic [CNT_W-1:0] Value,
    output logic             Busy,
    output logic             Done,
    output logic [1:0]       State
);

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] lv_q, tv_q;
    logic             lat_en;
    logic             cnt_load, cnt_count;
    logic [CNT_W-1:0] cnt_i;
    logic             carry_unused;

    always_ff @(posedge CLK or negedge Clear_b) begin
        if (!Clear_b) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
            lv_q    <= '0;
            tv_q    <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (lat_en) begin
                lv_q <= Load_val;
                tv_q <= Terminal;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        done_d    = 1'b0;
        lat_en    = 1'b0;
        cnt_load  = 1'b0;
        cnt_count = 1'b0;
        cnt_i     = '0;
        if (Abort) begin
            // Loading zero is the only way Value is cleared outside reset.
            state_d  = ST_IDLE;
            cnt_load = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (Start) begin
                        lat_en   = 1'b1;
                        cnt_load = 1'b1;
                        cnt_i    = Load_val;
                        state_d  = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (Pause) begin
                        state_d = ST_HOLD;
                    end else if (Value == tv_q) begin
                        done_d = 1'b1;
                        if (Auto_reload) begin
                            cnt_load = 1'b1;
                            cnt_i    = lv_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_count = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!Pause) state_d = ST_RUN;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    load_counter4 u_cnt (
        .CLK    (CLK),
        .Clear_b(Clear_b),
        .Load   (cnt_load),
        .Count  (cnt_count),
        .I      (cnt_i),
        .A      (Value),
        .C_out  (carry_unused)
    );

    assign State = state_q;
    assign Busy  = (state_q != ST_IDLE);
    assign Done  = done_q;

endmodule

// File: tb/tb_count_sequencer.sv
// Scoreboard bench for count_sequencer: a period-position reference model
// pushes expected outputs per edge, a monitor pops and compares.
module tb_count_sequencer;

    logic       CLK = 1'b0;
    logic       Clear_b = 1'b0;
    logic       Start = 1'b0, Pause = 1'b0, Abort = 1'b0, Auto_reload = 1'b0;
    logic [3:0] Load_val = '0, Terminal = '0;
    logic [3:0] Value;
    logic       Busy, Done;
    logic [1:0] State;

    typedef struct packed {
        logic [3:0] v;
        logic [1:0] s;
        logic       d;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // Reference model: mode 0 idle, 1 run, 2 hold; position within period.
    int   m_mode, m_val, m_lv, m_plen, m_pos;
    bit   m_done;

    count_sequencer dut (
        .CLK        (CLK),
        .Clear_b    (Clear_b),
        .Start      (Start),
        .Pause      (Pause),
        .Abort      (Abort),
        .Auto_reload(Auto_reload),
        .Load_val   (Load_val),
        .Terminal   (Terminal),
        .Value      (Value),
        .Busy       (Busy),
        .Done       (Done),
        .State      (State)
    );

    always #5 CLK = ~CLK;

    task automatic model_reset();
        m_mode = 0; m_val = 0; m_lv = 0; m_plen = 1; m_pos = 0; m_done = 0;
    endtask

    task automatic model_edge();
        m_done = 0;
        if (!Clear_b) begin
            model_reset();
        end else if (Abort) begin
            m_mode = 0; m_val = 0;
        end else if (m_mode == 0) begin
            if (Start) begin
                m_lv   = int'(Load_val);
                m_plen = ((int'(Terminal) - int'(Load_val) + 16) % 16) + 1;
                m_pos  = 0;
                m_val  = m_lv;
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (Pause) begin
                m_mode = 2;
            end else if (m_pos == m_plen - 1) begin
                m_done = 1;
                if (Auto_reload) begin m_pos = 0; m_val = m_lv; end
                else m_mode = 0;
            end else begin
                m_pos = m_pos + 1;
                m_val = (m_lv + m_pos) % 16;
            end
        end else begin
            if (!Pause) m_mode = 1;
        end
    endtask

    task automatic push_exp();
        exp_t e;
        e.v = m_val[3:0];
        e.s = m_mode[1:0];
        e.d = m_done;
        q.push_back(e);
    endtask

    // Drive one cycle of inputs, then model the edge they are sampled on.
    task automatic cyc(input bit st, input bit pa, input bit ab, input bit ar,
                       input int lv, input int tv);
        Start = st; Pause = pa; Abort = ab; Auto_reload = ar;
        Load_val = lv[3:0]; Terminal = tv[3:0];
        @(posedge CLK);
        model_edge();
        push_exp();
        @(negedge CLK);
    endtask

    task automatic idle(input int n, input bit ar);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, ar, 0, 0);
    endtask

    // Pulse Clear_b low between edges and check the outputs drop at once.
    task automatic async_reset();
        #2 Clear_b = 1'b0;
        #1;
        n_chk++;
        if (Value == 4'd0 && State == 2'd0 && !Done && !Busy) n_pass++;
        else $display("FAIL async_reset: got Value=%0d State=%0d Done=%0b Busy=%0b, want all zero",
                      Value, State, Done, Busy);
        Start = 0; Pause = 0; Abort = 0;
        @(posedge CLK);
        model_edge();
        push_exp();
        @(negedge CLK);
        #1 Clear_b = 1'b1;
    endtask

    always @(negedge CLK) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk++;
            if (Value == e.v && State == e.s && Done == e.d && Busy == (e.s != 2'd0))
                n_pass++;
            else
                $display("FAIL scoreboard t=%0t: got Value=%0d State=%0d Done=%0b Busy=%0b, want Value=%0d State=%0d Done=%0b Busy=%0b",
                         $time, Value, State, Done, Busy, e.v, e.s, e.d, (e.s != 2'd0));
        end
    end

    initial begin
        model_reset();
        @(negedge CLK);
        idle(2, 0);
        #1 Clear_b = 1'b1;

        // Single period 5..9.
        cyc(1, 0, 0, 0, 5, 9);
        idle(7, 0);

        // Wrapping auto-reload period 14,15,0,1.
        cyc(1, 0, 0, 1, 14, 1);
        idle(12, 1);
        cyc(0, 0, 1, 1, 0, 0);

        // Pause at Value 6 for three cycles.
        cyc(1, 0, 0, 0, 3, 8);
        idle(3, 0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0);
        idle(6, 0);

        // Abort on the terminal edge, then Start+Abort together in IDLE.
        cyc(1, 0, 0, 1, 5, 9);
        idle(4, 1);
        cyc(0, 0, 1, 1, 0, 0);
        cyc(1, 0, 1, 0, 2, 4);
        idle(3, 0);

        // Load_val == Terminal with reload: Done every cycle.
        cyc(1, 0, 0, 1, 7, 7);
        idle(5, 1);
        cyc(0, 0, 1, 0, 0, 0);

        // Asynchronous clear mid-run, then a clean restart.
        cyc(1, 0, 0, 0, 5, 9);
        idle(2, 0);
        async_reset();
        cyc(1, 0, 0, 0, 5, 9);
        idle(7, 0);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                cyc($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2,
                    $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
                    int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
            end
        end

        // Let the monitor drain, bounded.
        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge CLK);
        n_chk++;
        if (q.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected responses left, want 0", q.size());

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
